// File: rtl/lse_simd_pkg.sv
// Shared SIMD mode, carry-select and scheduler state definitions.
package lse_simd_pkg;

    // SIMD lane split requested by a client
    typedef enum logic [1:0] {
        MODE_1X32 = 2'd0,
        MODE_2X16 = 2'd1,
        MODE_4X8  = 2'd2,
        MODE_RSVD = 2'd3
    } simd_mode_e;

    // Carry-routing selects at lane boundaries 24/16/8; 1 = propagate
    localparam logic [2:0] CSEL_1X32 = 3'b111;
    localparam logic [2:0] CSEL_2X16 = 3'b101;
    localparam logic [2:0] CSEL_4X8  = 3'b000;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    // Reserved encoding executes as a full 32-bit operation
    function automatic simd_mode_e norm_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_2X16;
            2'd2:    return MODE_4X8;
            default: return MODE_1X32;
        endcase
    endfunction

    function automatic logic [2:0] mode_csel(input simd_mode_e m);
        case (m)
            MODE_2X16: return CSEL_2X16;
            MODE_4X8:  return CSEL_4X8;
            default:   return CSEL_1X32;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection; the pointer moves past the winner on advance.
module rr_arbiter
    import lse_simd_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic                       i_advance,
    output logic [N_REQ-1:0]           o_grant,
    output logic [$clog2(N_REQ)-1:0]   o_grant_idx,
    output logic                       o_found
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0]   r_ptr;
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W:0]     w_off;
    logic [IDX_W:0]     w_sum;

    // First requester at or after the pointer, found on a rotated copy
    always_comb begin
        w_dbl   = {i_req, i_req} >> r_ptr;
        w_rot   = w_dbl[N_REQ-1:0];
        w_off   = '0;
        o_found = 1'b0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (w_rot[i-1]) begin
                w_off   = (IDX_W+1)'(i-1);
                o_found = 1'b1;
            end
        end
        w_sum = {1'b0, r_ptr} + w_off;
        if (w_sum >= (IDX_W+1)'(N_REQ)) begin
            w_sum = w_sum - (IDX_W+1)'(N_REQ);
        end
        o_grant_idx = w_sum[IDX_W-1:0];
        o_grant     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            o_grant[k] = o_found && (o_grant_idx == IDX_W'(k));
        end
    end

    // Pointer moves to (granted + 1) mod N_REQ after each grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && o_found) begin
            r_ptr <= (o_grant_idx == IDX_W'(N_REQ-1)) ? '0 : o_grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/lse_simd_sched.sv
// Shares one SIMD multiplier datapath among N_REQ requesters, keeping the
// carry-routing mode constant while operations are in flight.
module lse_simd_sched
    import lse_simd_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DP_LAT = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req_valid,
    output logic [N_REQ-1:0]          o_req_ready,
    input  logic [N_REQ*DATA_W-1:0]   i_req_a,
    input  logic [N_REQ*DATA_W-1:0]   i_req_b,
    input  logic [N_REQ*2-1:0]        i_req_mode,
    output logic                      o_dp_valid,
    output logic [DATA_W-1:0]         o_dp_a,
    output logic [DATA_W-1:0]         o_dp_b,
    output logic [2:0]                o_dp_carry_sel,
    input  logic [DATA_W-1:0]         i_dp_result,
    output logic [N_REQ-1:0]          o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_err_mode
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    sched_state_e     r_state;
    sched_state_e     w_nstate;
    simd_mode_e       r_mode;
    simd_mode_e       w_win_mode;
    simd_mode_e       w_issue_mode;
    logic             r_run;
    logic             r_err;
    logic [DP_LAT-1:0] r_pipe_v;
    logic [IDX_W-1:0] r_pipe_tag [DP_LAT];

    logic [N_REQ-1:0] w_grant;
    logic [N_REQ-1:0] w_ready;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    logic             w_accept;
    logic             w_pend;
    logic [1:0]       w_win_raw;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req_valid),
        .i_advance   (w_accept),
        .o_grant     (w_grant),
        .o_grant_idx (w_idx),
        .o_found     (w_found)
    );

    // Winner's operands and mode; operands never feed the ready path
    always_comb begin
        w_win_raw = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (w_idx == IDX_W'(k)) begin
                w_win_raw = i_req_mode[2*k +: 2];
                w_sel_a   = i_req_a[k*DATA_W +: DATA_W];
                w_sel_b   = i_req_b[k*DATA_W +: DATA_W];
            end
        end
        w_win_mode = norm_mode(w_win_raw);
    end

    // Ops that will still be short of their result stage next cycle; an op
    // presenting its result this cycle no longer constrains the carry mode
    always_comb begin
        w_pend = 1'b0;
        for (int unsigned i = 0; i + 2 < DP_LAT; i++) begin
            w_pend = w_pend | r_pipe_v[i];
        end
    end

    // Next-state and ready generation
    always_comb begin
        w_nstate = r_state;
        w_ready  = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_run && w_found) begin
                    w_ready  = w_grant;
                    w_nstate = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_found) begin
                    if (w_win_mode == r_mode) begin
                        w_ready = w_grant;
                    end else begin
                        w_nstate = ST_DRAIN;
                    end
                end else if (!w_pend) begin
                    w_nstate = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!w_pend) begin
                    w_nstate = ST_IDLE;
                end
            end
            default: w_nstate = ST_IDLE;
        endcase
    end

    // Issue path: accepted op goes to the datapath in its accept cycle
    always_comb begin
        w_accept       = |(w_ready & i_req_valid);
        o_req_ready    = w_ready;
        o_dp_valid     = w_accept;
        o_dp_a         = w_accept ? w_sel_a : '0;
        o_dp_b         = w_accept ? w_sel_b : '0;
        w_issue_mode   = (r_state == ST_IDLE && w_accept) ? w_win_mode : r_mode;
        o_dp_carry_sel = mode_csel(w_issue_mode);
        o_err_mode     = r_err;
    end

    // Response path: tag at the last pipe stage selects the requester
    always_comb begin
        o_rsp_valid = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            o_rsp_valid[k] = r_pipe_v[DP_LAT-1] && (r_pipe_tag[DP_LAT-1] == IDX_W'(k));
        end
        o_rsp_data = r_pipe_v[DP_LAT-1] ? i_dp_result : '0;
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    // Run flag holds ready low while in reset; mode loads only when idle; sticky error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run  <= 1'b0;
            r_mode <= MODE_1X32;
            r_err  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_state == ST_IDLE && w_accept) begin
                r_mode <= w_win_mode;
            end
            if (w_accept && w_win_raw == 2'd3) begin
                r_err <= 1'b1;
            end
        end
    end

    // In-flight {valid, tag} shift register, DP_LAT deep
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe_v <= '0;
            for (int unsigned i = 0; i < DP_LAT; i++) begin
                r_pipe_tag[i] <= '0;
            end
        end else begin
            r_pipe_v[0]   <= w_accept;
            r_pipe_tag[0] <= w_idx;
            for (int unsigned i = 1; i < DP_LAT; i++) begin
                r_pipe_v[i]   <= r_pipe_v[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
        end
    end

endmodule

// File: tb/tb_lse_simd_sched.sv
// Directed bench for lse_simd_sched with a response scoreboard.
module tb_lse_simd_sched;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 3;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [N-1:0]     i_req_valid;
    logic [N-1:0]     o_req_ready;
    logic [N*W-1:0]   i_req_a;
    logic [N*W-1:0]   i_req_b;
    logic [N*2-1:0]   i_req_mode;
    logic             o_dp_valid;
    logic [W-1:0]     o_dp_a;
    logic [W-1:0]     o_dp_b;
    logic [2:0]       o_dp_carry_sel;
    logic [W-1:0]     i_dp_result;
    logic [N-1:0]     o_rsp_valid;
    logic [W-1:0]     o_rsp_data;
    logic             o_err_mode;

    always #5 i_clk = ~i_clk;

    lse_simd_sched #(.N_REQ(N), .DATA_W(W), .DP_LAT(LAT)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_a        (i_req_a),
        .i_req_b        (i_req_b),
        .i_req_mode     (i_req_mode),
        .o_dp_valid     (o_dp_valid),
        .o_dp_a         (o_dp_a),
        .o_dp_b         (o_dp_b),
        .o_dp_carry_sel (o_dp_carry_sel),
        .i_dp_result    (i_dp_result),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_data     (o_rsp_data),
        .o_err_mode     (o_err_mode)
    );

    function automatic logic [W-1:0] dp_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001;
    endfunction

    // Datapath stand-in: fixed LAT-cycle delay of dp_fn(a, b)
    logic [W-1:0] dp_q [LAT];
    always @(posedge i_clk) begin
        dp_q[0] <= o_dp_valid ? dp_fn(o_dp_a, o_dp_b) : '0;
        for (int i = 1; i < LAT; i++) dp_q[i] <= dp_q[i-1];
    end
    assign i_dp_result = dp_q[LAT-1];

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int           due;
        logic [N-1:0] tag_oh;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb[$];

    // Response monitor: exactly the due responses, nothing else
    logic mon_en = 1'b0;
    always @(negedge i_clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                chk("rsp_valid", 32'(o_rsp_valid), 32'(sb[0].tag_oh));
                chk("rsp_data", o_rsp_data, sb[0].data);
                void'(sb.pop_front());
            end else begin
                chk("rsp_idle", 32'(o_rsp_valid), 32'd0);
            end
        end
    end

    logic [W-1:0] ra [N];
    logic [W-1:0] rb [N];
    logic [1:0]   rm [N];

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            i_req_a[k*W +: W]  = ra[k];
            i_req_b[k*W +: W]  = rb[k];
            i_req_mode[k*2 +: 2] = rm[k];
        end
    endtask

    task automatic next();
        @(posedge i_clk);
        #1;
    endtask

    task automatic step_issue(input int k, input logic [2:0] csel, input string tag);
        exp_t e;
        @(negedge i_clk);
        chk({tag, "_dpv"},   32'(o_dp_valid), 32'd1);
        chk({tag, "_ready"}, 32'(o_req_ready), 32'd1 << k);
        chk({tag, "_a"},     o_dp_a, ra[k]);
        chk({tag, "_b"},     o_dp_b, rb[k]);
        chk({tag, "_csel"},  32'(o_dp_carry_sel), 32'(csel));
        e.due    = cyc + LAT;
        e.tag_oh = N'(1) << k;
        e.data   = dp_fn(ra[k], rb[k]);
        sb.push_back(e);
    endtask

    task automatic step_none(input logic [2:0] csel, input string tag);
        @(negedge i_clk);
        chk({tag, "_dpv"},   32'(o_dp_valid), 32'd0);
        chk({tag, "_ready"}, 32'(o_req_ready), 32'd0);
        chk({tag, "_csel"},  32'(o_dp_carry_sel), 32'(csel));
    endtask

    task automatic idle(input int n, input logic [2:0] csel, input string tag);
        for (int i = 0; i < n; i++) begin
            next();
            i_req_valid = '0;
            step_none(csel, tag);
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            ra[k] = $urandom;
            rb[k] = $urandom;
        end
    endtask

    initial begin
        // Reset with all requesters valid: ready must stay low
        i_rst_n     = 1'b0;
        i_req_valid = '1;
        for (int k = 0; k < N; k++) rm[k] = 2'd0;
        rand_ops();
        apply();
        #2;
        chk("rst_ready", 32'(o_req_ready), 32'd0);
        chk("rst_dpv",   32'(o_dp_valid), 32'd0);
        chk("rst_a",     o_dp_a, 32'd0);
        chk("rst_csel",  32'(o_dp_carry_sel), 32'b111);
        chk("rst_rspv",  32'(o_rsp_valid), 32'd0);
        chk("rst_rspd",  o_rsp_data, 32'd0);
        chk("rst_err",   32'(o_err_mode), 32'd0);
        i_req_valid = '0;
        next();
        next();
        i_rst_n = 1'b1;
        mon_en  = 1'b1;
        idle(1, 3'b111, "post_rst");

        // All four valid in mode 0: grants 0,1,2,3,0,1,2,3 back to back
        for (int c = 0; c < 8; c++) begin
            next();
            rand_ops();
            i_req_valid = 4'hF;
            apply();
            step_issue(c % 4, 3'b111, "rr");
        end
        idle(4, 3'b111, "rr_end");

        // req0 mode 0 then req1 mode 2: req1 waits for the drain
        next();
        rand_ops();
        rm[0] = 2'd0;
        rm[1] = 2'd2;
        i_req_valid = 4'b0011;
        apply();
        step_issue(0, 3'b111, "mc_req0");
        next();
        i_req_valid = 4'b0010;
        step_none(3'b111, "mc_drain1");
        next();
        step_none(3'b111, "mc_drain2");
        next();
        step_issue(1, 3'b000, "mc_req1");
        idle(4, 3'b000, "mc_end");

        // Reserved mode on req2: runs as 1x32 and sets the sticky error
        @(negedge i_clk);
        chk("err_before", 32'(o_err_mode), 32'd0);
        next();
        rand_ops();
        rm[2] = 2'd3;
        ra[2] = 32'h0000FFFF;
        i_req_valid = 4'b0100;
        apply();
        step_issue(2, 3'b111, "rsvd");
        for (int i = 0; i < 2; i++) begin
            next();
            rand_ops();
            rm[2] = 2'd0;
            apply();
            step_issue(2, 3'b111, "rsvd_legal");
            chk("err_sticky", 32'(o_err_mode), 32'd1);
        end
        idle(4, 3'b111, "rsvd_end");
        chk("err_hold", 32'(o_err_mode), 32'd1);

        // Only req3 valid, mode 1: five consecutive issues
        rm[3] = 2'd1;
        for (int i = 0; i < 5; i++) begin
            next();
            rand_ops();
            i_req_valid = 4'b1000;
            apply();
            step_issue(3, 3'b101, "solo");
        end
        idle(4, 3'b101, "solo_end");

        // Reset with two ops in flight: nothing comes back for them
        next();
        rand_ops();
        rm[0] = 2'd0;
        rm[1] = 2'd0;
        i_req_valid = 4'b0011;
        apply();
        step_issue(0, 3'b111, "fl0");
        next();
        rand_ops();
        apply();
        step_issue(1, 3'b111, "fl1");
        next();
        i_rst_n = 1'b0;
        #1;
        chk("mid_ready", 32'(o_req_ready), 32'd0);
        chk("mid_dpv",   32'(o_dp_valid), 32'd0);
        chk("mid_a",     o_dp_a, 32'd0);
        chk("mid_b",     o_dp_b, 32'd0);
        chk("mid_csel",  32'(o_dp_carry_sel), 32'b111);
        chk("mid_rspv",  32'(o_rsp_valid), 32'd0);
        chk("mid_rspd",  o_rsp_data, 32'd0);
        chk("mid_err",   32'(o_err_mode), 32'd0);
        sb.delete();
        next();
        i_rst_n = 1'b1;
        i_req_valid = '0;
        step_none(3'b111, "post_mid0");
        idle(6, 3'b111, "post_mid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lse_simd_sched.md
LSE_SIMD_SCHED -- requirements
Module: lse_simd_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one lse_mult_simd datapath (2..8).
REQ-002 SHALL have parameter DATA_W, default 32, operand and result width (multiple of 32).
REQ-003 SHALL have parameter DP_LAT, default 3, fixed datapath latency in cycles (1..8).
REQ-004 SHALL have port i_clk  in  1  the single clock.
REQ-005 SHALL have port i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port i_req_valid  in  N_REQ  per-requester operation valid.
REQ-007 SHALL have port o_req_ready  out  N_REQ  per-requester accept; one-hot or zero.
REQ-008 SHALL have port i_req_a, i_req_b  in  N_REQ*DATA_W  packed operands, requester k at slice k.
REQ-009 SHALL have port i_req_mode  in  N_REQ*2  SIMD mode per requester: 0=1x32, 1=2x16, 2=4x8, 3=reserved.
REQ-010 SHALL have port o_dp_valid  out  1  datapath issue strobe.
REQ-011 SHALL have port o_dp_a, o_dp_b  out  DATA_W  issued operands.
REQ-012 SHALL have port o_dp_carry_sel  out  3  carry-routing mux selects at lane boundaries 8/16/24; 1 = propagate.
REQ-013 SHALL have port i_dp_result  in  DATA_W  datapath result, valid DP_LAT cycles after issue.
REQ-014 SHALL have port o_rsp_valid  out  N_REQ  one-hot response strobe to the issuing requester.
REQ-015 SHALL have port o_rsp_data  out  DATA_W  response data, shared by all requesters.
REQ-016 SHALL have port o_err_mode  out  1  sticky flag: a mode-3 request was accepted.

Function
REQ-017 SHALL arbitrate round-robin: pointer starts at requester 0, moves to (granted+1) mod N_REQ after every grant.
REQ-018 SHALL accept a request when i_req_valid[k] and o_req_ready[k] are both high in one cycle; at most one accept per cycle.
REQ-019 SHALL drive o_req_ready combinationally from state and arbitration only, never from i_req_a/i_req_b.
REQ-020 SHALL issue an accepted request in the same cycle: o_dp_valid=1, operands forwarded, o_dp_carry_sel from mode (0->111, 1->101, 2->000).
REQ-021 SHALL treat mode 3 as mode 0 and set o_err_mode, which stays set until reset.
REQ-022 SHALL keep carry_sel register holding the current mode, changed only when pipeline is empty.
REQ-023 SHALL implement FSM IDLE, ISSUE, DRAIN; IDLE = pipeline empty, ISSUE = ops in flight with current mode, DRAIN = waiting for pipeline empty before mode change.
REQ-024 SHALL move IDLE->ISSUE on any accept, loading that request's mode into carry_sel in the same cycle.
REQ-025 SHALL in ISSUE grant only the round-robin winner; if its mode equals current mode, accept; otherwise deassert all ready and go to DRAIN.
REQ-026 SHALL in DRAIN keep o_req_ready all zero and go to IDLE when in-flight count reaches 0.
REQ-027 SHALL go ISSUE->IDLE when the in-flight count reaches 0 and no accept occurs.
REQ-028 SHALL track in-flight ops with a DP_LAT-deep shift register of {valid, tag}; tag = granted index.
REQ-029 SHALL pulse o_rsp_valid[tag] and present i_dp_result on o_rsp_data exactly DP_LAT cycles after issue; no response backpressure.
REQ-030 SHALL sustain one issue per cycle while the winner's mode matches the current mode.
REQ-031 SHALL never issue while o_dp_carry_sel differs from the mode of any in-flight op.

Reset
REQ-032 SHALL on i_rst_n low immediately clear: o_req_ready=0, o_dp_valid=0, o_dp_a=o_dp_b=0, o_dp_carry_sel=111, o_rsp_valid=0, o_rsp_data=0, o_err_mode=0, FSM=IDLE, RR pointer=0, in-flight pipe empty.
REQ-033 SHALL discard in-flight ops on mid-operation reset; no response is emitted for them after release.

Structure
REQ-034 SHALL place the mode enum, the mode-to-carry_sel constants and the FSM state typedef in shared package lse_simd_pkg.
REQ-035 SHALL implement the round-robin winner logic as sub-module rr_arbiter (N_REQ param, req in, grant out, advance strobe).

Verification
REQ-036 SHALL test: all 4 requesters valid, mode 0, held 8 cycles -> grants 0,1,2,3,0,1,2,3, one per cycle, each o_rsp_valid DP_LAT=3 cycles after issue.
REQ-037 SHALL test: req0 mode 0 then req1 mode 2 back-to-back -> req1 held in DRAIN, issued 3 cycles after req0's issue, carry_sel 111 then 000.
REQ-038 SHALL test: req2 mode 3, a=0x0000FFFF -> carry_sel=111, o_err_mode=1 and stays 1 after further legal ops.
REQ-039 SHALL test: reset asserted with 2 ops in flight -> all outputs zero immediately, no o_rsp_valid after release.
REQ-040 SHALL test: only req3 valid, mode 1, 5 ops -> 5 consecutive issues, carry_sel=101, responses tagged 0b1000.
